mmio_arbiter: RTL and testbench

- Shares one MMIO slave port between MST_NUM requesting masters using round-robin arbitration.
- Accepts at most one write or read transaction per cycle and drives the slave port from registers.
- Tracks the owner of each read through a fixed-latency pipeline and returns rd_data to that master only.
- Sits between CPU/DMA-side masters and the MMIO multiplexor that fans out to slaves.

---
 rtl/mmio_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/mmio_arbiter.sv | 124 ++++++++++++
 tb/tb_mmio_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// rtl/mmio_arb_pkg.sv - shared types and helpers for mmio_arbiter
package mmio_arb_pkg;

  // Widest master id an owner entry can carry (up to 256 masters).
  localparam int OWNER_ID_W = 8;

  function automatic int id_width(input int mst_num);
    return (mst_num > 1) ? $clog2(mst_num) : 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [OWNER_ID_W-1:0] id;
  } owner_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with a registered priority pointer
module rr_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int MST_NUM = 2,
  localparam int ID_W = id_width(MST_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MST_NUM-1:0] req,
  input  logic               advance,
  output logic [MST_NUM-1:0] gnt,
  output logic [ID_W-1:0]    winner
);

  localparam logic [ID_W:0] N = (ID_W+1)'(MST_NUM);

  logic [ID_W-1:0]    ptr;
  logic [MST_NUM-1:0] rot;
  logic [ID_W:0]      idx;
  logic               found;

  // rot[i] is the request of master (ptr + i) mod MST_NUM.
  assign rot = MST_NUM'({req, req} >> ptr);

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = {1'b0, ptr} + (ID_W+1)'(i);
        if (idx >= N) idx = idx - N;
        winner = idx[ID_W-1:0];
      end
    end
    if (found && !rst_i) gnt = MST_NUM'(1) << winner;
  end

  generate
    if (MST_NUM == 1) begin : g_single
      assign ptr = '0;
    end else begin : g_multi
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ptr <= '0;
        end else if (advance) begin
          ptr <= (winner == ID_W'(MST_NUM - 1)) ? '0 : winner + ID_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - round-robin sharing of one MMIO slave port between masters
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int A_WIDTH    = 32,
  parameter int D_WIDTH    = 32,
  parameter int MST_NUM    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [MST_NUM-1:0]           m_req_i,
  input  logic [MST_NUM-1:0]           m_wr_i,
  input  logic [MST_NUM*A_WIDTH-1:0]   m_addr_i,
  input  logic [MST_NUM*D_WIDTH-1:0]   m_wdata_i,
  input  logic [MST_NUM*D_WIDTH/8-1:0] m_byteen_i,
  output logic [MST_NUM-1:0]           m_gnt_o,
  output logic [MST_NUM-1:0]           m_rvalid_o,
  output logic [D_WIDTH-1:0]           m_rdata_o,
  output logic                         wr_en_o,
  output logic [A_WIDTH-1:0]           wr_addr_o,
  output logic [D_WIDTH-1:0]           wr_data_o,
  output logic [D_WIDTH/8-1:0]         wr_byteen_o,
  output logic                         rd_en_o,
  output logic [A_WIDTH-1:0]           rd_addr_o,
  input  logic [D_WIDTH-1:0]           rd_data_i
);

  localparam int ID_W = id_width(MST_NUM);
  localparam int BE_W = D_WIDTH / 8;

  logic [MST_NUM-1:0] gnt;
  logic [ID_W-1:0]    winner;
  logic               xfer;
  logic               sel_wr;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]    sel_byteen;
  logic [ID_W-1:0]    issue_id;

  owner_t [RD_LATENCY-1:0] owner_pipe;
  owner_t                  owner_tail;

  rr_arbiter #(
    .MST_NUM (MST_NUM)
  ) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (m_req_i),
    .advance (xfer),
    .gnt     (gnt),
    .winner  (winner)
  );

  assign m_gnt_o = gnt;
  assign xfer    = |(gnt & m_req_i);

  always_comb begin
    sel_wr     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_byteen = '0;
    for (int k = 0; k < MST_NUM; k++) begin
      if (gnt[k]) begin
        sel_wr     = m_wr_i[k];
        sel_addr   = m_addr_i[k*A_WIDTH +: A_WIDTH];
        sel_wdata  = m_wdata_i[k*D_WIDTH +: D_WIDTH];
        sel_byteen = m_byteen_i[k*BE_W +: BE_W];
      end
    end
  end

  // Address/data hold their last values when nothing is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_o     <= 1'b0;
      rd_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_byteen_o <= '0;
      rd_addr_o   <= '0;
      issue_id    <= '0;
    end else begin
      wr_en_o <= xfer && sel_wr;
      rd_en_o <= xfer && !sel_wr;
      if (xfer && sel_wr) begin
        wr_addr_o   <= sel_addr;
        wr_data_o   <= sel_wdata;
        wr_byteen_o <= sel_byteen;
      end
      if (xfer && !sel_wr) begin
        rd_addr_o <= sel_addr;
        issue_id  <= winner;
      end
    end
  end

  // Owner entry enters when rd_en_o is on the port and leaves with rd_data_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_pipe <= '0;
    end else begin
      owner_pipe[0] <= {rd_en_o, OWNER_ID_W'(issue_id)};
      for (int i = 1; i < RD_LATENCY; i++) begin
        owner_pipe[i] <= owner_pipe[i-1];
      end
    end
  end

  assign owner_tail = owner_pipe[RD_LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_rvalid_o <= '0;
      m_rdata_o  <= '0;
    end else begin
      for (int k = 0; k < MST_NUM; k++) begin
        m_rvalid_o[k] <= owner_tail.valid && (owner_tail.id == OWNER_ID_W'(k));
      end
      if (owner_tail.valid) m_rdata_o <= rd_data_i;
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb/tb_mmio_arbiter.sv - randomized self-checking bench for mmio_arbiter
module tb_mmio_arbiter;

  localparam int MST = 4;
  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;

  logic               clk;
  logic               rst;
  logic [MST-1:0]     m_req;
  logic [MST-1:0]     m_wr;
  logic [MST*AW-1:0]  m_addr;
  logic [MST*DW-1:0]  m_wdata;
  logic [MST*BEW-1:0] m_byteen;
  logic [MST-1:0]     m_gnt;
  logic [MST-1:0]     m_rvalid;
  logic [DW-1:0]      m_rdata;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [BEW-1:0]     wr_byteen;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;

  logic [AW-1:0]  a_addr  [MST];
  logic [DW-1:0]  a_wdata [MST];
  logic [BEW-1:0] a_be    [MST];

  logic [DW-1:0]  spipe [LAT];

  int             ptr_m;
  logic           e_wr_en, e_rd_en;
  logic [AW-1:0]  e_wa, e_ra;
  logic [DW-1:0]  e_wd;
  logic [BEW-1:0] e_be;
  logic [MST-1:0] ev_rv [8];
  logic [DW-1:0]  ev_rd [8];

  int             cyc;
  int             n_cmp;
  int             n_err;
  int             dens;
  int             wr_pct;
  logic [MST-1:0] en_mask;

  mmio_arbiter #(
    .A_WIDTH    (AW),
    .D_WIDTH    (DW),
    .MST_NUM    (MST),
    .RD_LATENCY (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_req_i     (m_req),
    .m_wr_i      (m_wr),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_byteen_i  (m_byteen),
    .m_gnt_o     (m_gnt),
    .m_rvalid_o  (m_rvalid),
    .m_rdata_o   (m_rdata),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_byteen_o (wr_byteen),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_addr   = '0;
    m_wdata  = '0;
    m_byteen = '0;
    for (int k = 0; k < MST; k++) begin
      m_addr[k*AW +: AW]     = a_addr[k];
      m_wdata[k*DW +: DW]    = a_wdata[k];
      m_byteen[k*BEW +: BEW] = a_be[k];
    end
  end

  // Slave: returns addr+1 LAT cycles after rd_en, garbage otherwise.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) spipe[i] <= spipe[i-1];
    spipe[0] <= rd_en ? rd_addr + 1 : $urandom;
  end
  assign rd_data = spipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int j, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BEW-1:0] be);
    m_req[j]   = 1'b1;
    m_wr[j]    = wr;
    a_addr[j]  = addr;
    a_wdata[j] = data;
    a_be[j]    = be;
  endtask

  task automatic new_req(input int j);
    if (en_mask[j] && ($urandom_range(99) < dens)) begin
      set_req(j, ($urandom_range(99) < wr_pct), $urandom, $urandom, BEW'($urandom));
    end else begin
      m_req[j] = 1'b0;
    end
  endtask

  // Called in the low phase with this cycle's inputs already applied.
  task automatic tick();
    int w;
    int k;
    int s;
    #1;
    w = -1;
    if (!rst) begin
      for (int i = 0; i < MST; i++) begin
        k = (ptr_m + i) % MST;
        if (w < 0 && m_req[k]) w = k;
      end
    end
    chk("gnt", m_gnt, (w < 0) ? 64'd0 : (64'd1 << w));
    chk("wr_en", wr_en, e_wr_en);
    chk("rd_en", rd_en, e_rd_en);
    chk("wr_addr", wr_addr, e_wa);
    chk("wr_data", wr_data, e_wd);
    chk("wr_byteen", wr_byteen, e_be);
    chk("rd_addr", rd_addr, e_ra);
    s = cyc % 8;
    chk("rvalid", m_rvalid, ev_rv[s]);
    if (ev_rv[s] != '0) chk("rdata", m_rdata, ev_rd[s]);
    ev_rv[s] = '0;

    if (rst) begin
      ptr_m = 0; e_wr_en = 0; e_rd_en = 0;
      e_wa = '0; e_wd = '0; e_be = '0; e_ra = '0;
      for (int i = 0; i < 8; i++) ev_rv[i] = '0;
    end else begin
      e_wr_en = 0;
      e_rd_en = 0;
      if (w >= 0) begin
        if (m_wr[w]) begin
          e_wr_en = 1; e_wa = a_addr[w]; e_wd = a_wdata[w]; e_be = a_be[w];
        end else begin
          e_rd_en = 1; e_ra = a_addr[w];
          ev_rv[(cyc + LAT + 2) % 8] = MST'(1 << w);
          ev_rd[(cyc + LAT + 2) % 8] = a_addr[w] + 1;
        end
        ptr_m = (w + 1) % MST;
      end
    end

    @(negedge clk);
    for (int j = 0; j < MST; j++) begin
      if (j == w || !m_req[j]) new_req(j);
    end
    cyc++;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    dens = 0; wr_pct = 50; en_mask = '0;
    m_req = '0; m_wr = '0; rst = 1'b1;
    ptr_m = 0; e_wr_en = 0; e_rd_en = 0;
    e_wa = '0; e_wd = '0; e_be = '0; e_ra = '0;
    for (int i = 0; i < MST; i++) begin
      a_addr[i] = '0; a_wdata[i] = '0; a_be[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      ev_rv[i] = '0; ev_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (10) tick();

    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    repeat (3) tick();

    rst = 1'b1; tick(); rst = 1'b0;
    en_mask = 4'b0011; dens = 100; wr_pct = 0;
    set_req(0, 1'b0, 32'h4, '0, '0);
    set_req(1, 1'b0, 32'h8, '0, '0);
    repeat (12) tick();
    en_mask = '0;
    repeat (6) tick();

    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b0, 32'h20, '0, '0);
    tick();
    set_req(0, 1'b1, 32'h30, 32'h1234, 4'h3);
    set_req(1, 1'b0, 32'h40, '0, '0);
    repeat (6) tick();

    rst = 1'b1; tick(); rst = 1'b0;
    set_req(1, 1'b0, 32'h50, '0, '0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b0, 32'h60, '0, '0);
    set_req(1, 1'b0, 32'h70, '0, '0);
    repeat (8) tick();

    rst = 1'b1; tick(); rst = 1'b0;
    en_mask = 4'b1100; dens = 100; wr_pct = 50;
    set_req(2, 1'b0, 32'h80, '0, '0);
    set_req(3, 1'b1, 32'h90, 32'hBEEF, 4'h1);
    repeat (12) tick();
    en_mask = '0;
    repeat (6) tick();

    en_mask = '1;
    for (int p = 0; p < 3; p++) begin
      dens = (p == 0) ? 30 : (p == 1) ? 70 : 100;
      for (int c = 0; c < 300; c++) begin
        rst = (p == 1) && ($urandom_range(63) == 0);
        tick();
      end
    end
    rst = 1'b0;
    en_mask = '0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
